// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results own the register-file port, FPU results bypass or queue.
// Optional macro WB_ERR_EN builds the sticky overflow flag and a simulation overflow message.
module wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [ADDR_W-1:0]             alu_addr,
   input  logic [DATA_W-1:0]             alu_dd_val,
   input  logic [ADDR_W-1:0]             fpu_addr,
   input  logic [DATA_W-1:0]             fpu_dd_val,
   output logic                          wb_en,
   output logic [ADDR_W-1:0]             wb_addr,
   output logic [DATA_W-1:0]             wb_val,
   output logic [$clog2(FIFO_DEPTH):0]   fq_count,
   output logic                          fpu_stall,
   output logic                          wb_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] r_mem_val  [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_wb_en;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [DATA_W-1:0] r_wb_val;

   logic w_alu_v;
   logic w_fpu_v;
   logic w_empty;
   logic w_full;
   logic w_deq;
   logic w_enq_req;
   logic w_enq;

   assign w_alu_v   = (alu_addr != '0);
   assign w_fpu_v   = (fpu_addr != '0);
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_deq     = !w_alu_v && !w_empty;
   // FPU result must queue whenever it cannot go straight to the port.
   assign w_enq_req = w_fpu_v && (w_alu_v || !w_empty);
   assign w_enq     = w_enq_req && (!w_full || w_deq);

   // Queue storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem_addr[r_wr_ptr] <= fpu_addr;
         r_mem_val[r_wr_ptr]  <= fpu_dd_val;
      end
   end

   // Arbitration, registered write port, queue pointers and occupancy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_val  <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
      end else begin
         if (w_alu_v) begin
            r_wb_en   <= 1'b1;
            r_wb_addr <= alu_addr;
            r_wb_val  <= alu_dd_val;
         end else if (!w_empty) begin
            r_wb_en   <= 1'b1;
            r_wb_addr <= r_mem_addr[r_rd_ptr];
            r_wb_val  <= r_mem_val[r_rd_ptr];
         end else if (w_fpu_v) begin
            r_wb_en   <= 1'b1;
            r_wb_addr <= fpu_addr;
            r_wb_val  <= fpu_dd_val;
         end else begin
            r_wb_en   <= 1'b0;
         end
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_deq && !w_enq) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

`ifdef WB_ERR_EN
   logic w_ovf;
   logic r_err;

   assign w_ovf = w_enq_req && w_full && !w_deq;

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_err <= 1'b0;
      end else if (w_ovf) begin
         r_err <= 1'b1;
      end
   end

   assign wb_err = r_err;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rstn && w_ovf) begin
         $error("wb_arbiter: FPU result dropped, queue overflow (addr %0d)", fpu_addr);
      end
   end
`endif
`else
   assign wb_err = 1'b0;
`endif

   assign wb_en     = r_wb_en;
   assign wb_addr   = r_wb_addr;
   assign wb_val    = r_wb_val;
   assign fq_count  = r_count;
   assign fpu_stall = (r_count >= CNT_W'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default parameters).
module tb_wb_arbiter;

   logic        clk;
   logic        rstn;
   logic [5:0]  alu_addr;
   logic [31:0] alu_dd_val;
   logic [5:0]  fpu_addr;
   logic [31:0] fpu_dd_val;
   logic        wb_en;
   logic [5:0]  wb_addr;
   logic [31:0] wb_val;
   logic [2:0]  fq_count;
   logic        fpu_stall;
   logic        wb_err;

   int n_pass  = 0;
   int n_total = 0;

`ifdef WB_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   wb_arbiter dut (
      .clk        (clk),
      .rstn       (rstn),
      .alu_addr   (alu_addr),
      .alu_dd_val (alu_dd_val),
      .fpu_addr   (fpu_addr),
      .fpu_dd_val (fpu_dd_val),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_val     (wb_val),
      .fq_count   (fq_count),
      .fpu_stall  (fpu_stall),
      .wb_err     (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] aa, input logic [31:0] av,
                        input logic [5:0] fa, input logic [31:0] fv);
      alu_addr   = aa;
      alu_dd_val = av;
      fpu_addr   = fa;
      fpu_dd_val = fv;
   endtask

   task automatic chk_wb(input string tag, input logic en, input logic [5:0] a,
                         input logic [31:0] v, input logic [2:0] cnt);
      chk({tag, ".en"},  32'(wb_en),    32'(en));
      chk({tag, ".addr"}, 32'(wb_addr), 32'(a));
      chk({tag, ".val"},  wb_val,       v);
      chk({tag, ".cnt"},  32'(fq_count), 32'(cnt));
   endtask

   initial begin
      rstn = 1'b0;
      drive(6'd0, 32'h0, 6'd0, 32'h0);
      #12;
      chk_wb("reset", 1'b0, 6'd0, 32'h0, 3'd0);
      chk("reset.stall", 32'(fpu_stall), 32'd0);
      chk("reset.err",   32'(wb_err),    32'd0);
      rstn = 1'b1;
      tick();

      // T1: ALU only
      drive(6'd5, 32'h1234, 6'd0, 32'h0);
      tick();
      chk_wb("t1.write", 1'b1, 6'd5, 32'h1234, 3'd0);
      drive(6'd0, 32'h0, 6'd0, 32'h0);
      tick();
      chk_wb("t1.idle", 1'b0, 6'd5, 32'h1234, 3'd0);

      // T2: FPU bypass
      drive(6'd0, 32'h0, 6'd40, 32'h3F80_0000);
      tick();
      chk_wb("t2.bypass", 1'b1, 6'd40, 32'h3F80_0000, 3'd0);
      drive(6'd0, 32'h0, 6'd0, 32'h0);
      tick();
      chk("t2.idle.en", 32'(wb_en), 32'd0);

      // T3: collision
      drive(6'd3, 32'hA, 6'd33, 32'hB);
      tick();
      chk_wb("t3.alu", 1'b1, 6'd3, 32'hA, 3'd1);
      drive(6'd0, 32'h0, 6'd0, 32'h0);
      tick();
      chk_wb("t3.fpu", 1'b1, 6'd33, 32'hB, 3'd0);
      tick();
      chk("t3.idle.en", 32'(wb_en), 32'd0);

      // T4: fill the queue behind a busy ALU
      for (int k = 0; k < 4; k++) begin
         drive(6'(10 + k), 32'(100 + k), 6'(33 + k), 32'(200 + k));
         tick();
         chk_wb("t4.fill", 1'b1, 6'(10 + k), 32'(100 + k), 3'(k + 1));
         chk("t4.stall", 32'(fpu_stall), (k >= 2) ? 32'd1 : 32'd0);
      end

      // T5: overflow drops addr 37
      drive(6'd14, 32'h0E, 6'd37, 32'h37);
      tick();
      chk_wb("t5.ovf", 1'b1, 6'd14, 32'h0E, 3'd4);
      chk("t5.err", 32'(wb_err), 32'(EXP_ERR));
      // Full queue: dequeue 33 while enqueueing 38, count stays 4
      drive(6'd0, 32'h0, 6'd38, 32'h38);
      tick();
      chk_wb("t5.swap", 1'b1, 6'd33, 32'd200, 3'd4);
      drive(6'd0, 32'h0, 6'd0, 32'h0);
      tick();
      chk_wb("t5.drain34", 1'b1, 6'd34, 32'd201, 3'd3);
      tick();
      chk_wb("t5.drain35", 1'b1, 6'd35, 32'd202, 3'd2);
      tick();
      chk_wb("t5.drain36", 1'b1, 6'd36, 32'd203, 3'd1);
      tick();
      chk_wb("t5.drain38", 1'b1, 6'd38, 32'h38, 3'd0);
      tick();
      chk("t5.idle.en",  32'(wb_en),     32'd0);
      chk("t5.err.hold", 32'(wb_err),    32'(EXP_ERR));
      chk("t5.stall",    32'(fpu_stall), 32'd0);

      // T6: async reset mid-drain
      for (int k = 0; k < 4; k++) begin
         drive(6'(20 + k), 32'(300 + k), 6'(41 + k), 32'(400 + k));
         tick();
      end
      chk("t6.full", 32'(fq_count), 32'd4);
      drive(6'd0, 32'h0, 6'd0, 32'h0);
      tick();
      chk_wb("t6.drain41", 1'b1, 6'd41, 32'd400, 3'd3);
      #2;
      rstn = 1'b0;
      #1;
      chk("t6.rst.en",    32'(wb_en),     32'd0);
      chk("t6.rst.cnt",   32'(fq_count),  32'd0);
      chk("t6.rst.stall", 32'(fpu_stall), 32'd0);
      chk("t6.rst.err",   32'(wb_err),    32'd0);
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t6.nostale.en",  32'(wb_en),    32'd0);
         chk("t6.nostale.cnt", 32'(fq_count), 32'd0);
      end
      drive(6'd7, 32'hCAFE, 6'd0, 32'h0);
      tick();
      chk_wb("t6.after", 1'b1, 6'd7, 32'hCAFE, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
